// File: rtl/cordic_rotator.sv
// Fully pipelined CORDIC vector rotator: rotates (x, y) by angle a and removes the
// CORDIC gain, producing a Q1.8 result 15 clocks after the sample is applied.
module cordic_rotator #(
    parameter int ITER = 12,
    parameter int IW   = 18
) (
    input  logic        clk,
    input  logic        areset,
    input  logic [12:0] a,
    input  logic [11:0] x,
    input  logic [11:0] y,
    output logic [9:0]  xo,
    output logic [9:0]  yo
);

    localparam int ZW  = 18;
    localparam int PW  = IW + 17;
    localparam int RND = 1 << 21;
    localparam logic signed [16:0] KINV = 17'sd39797;

    function automatic logic signed [ZW-1:0] atan_rom(input int unsigned i);
        case (i)
            0:  atan_rom = 18'sd12868;
            1:  atan_rom = 18'sd7596;
            2:  atan_rom = 18'sd4014;
            3:  atan_rom = 18'sd2037;
            4:  atan_rom = 18'sd1023;
            5:  atan_rom = 18'sd512;
            6:  atan_rom = 18'sd256;
            7:  atan_rom = 18'sd128;
            8:  atan_rom = 18'sd64;
            9:  atan_rom = 18'sd32;
            10: atan_rom = 18'sd16;
            11: atan_rom = 18'sd8;
            12: atan_rom = 18'sd4;
            13: atan_rom = 18'sd2;
            14: atan_rom = 18'sd1;
            default: atan_rom = '0;
        endcase
    endfunction

    // Q.14 value times K^-1 (Q0.16) gives Q.30; round half away from zero into Q1.8.
    function automatic logic [9:0] gain_round_sat(input logic signed [IW-1:0] v);
        logic signed [PW-1:0] p;
        logic signed [PW-1:0] bias;
        logic signed [PW-1:0] s;
        p    = PW'(v) * PW'(KINV);
        bias = p[PW-1] ? PW'(RND - 1) : PW'(RND);
        s    = (p + bias) >>> 22;
        if (s > PW'(511))
            gain_round_sat = 10'h1FF;
        else if (s < PW'(-512))
            gain_round_sat = 10'h200;
        else
            gain_round_sat = s[9:0];
    endfunction

    logic [12:0] a0;
    logic [11:0] x0;
    logic [11:0] y0;

    logic signed [IW-1:0] xp [0:ITER];
    logic signed [IW-1:0] yp [0:ITER];
    logic signed [ZW-1:0] zp [0:ITER];

    logic signed [13:0]   a_ext;
    logic signed [13:0]   a_red;
    logic signed [13:0]   z_pre;
    logic signed [IW-1:0] xs;
    logic signed [IW-1:0] ys;
    logic signed [IW-1:0] x_pre;
    logic signed [IW-1:0] y_pre;

    always_comb begin
        a_ext = {a0[12], a0};
        a_red = a_ext;
        if (a_ext > 14'sd3217)
            a_red = a_ext - 14'sd6434;
        else if (a_ext < -14'sd3217)
            a_red = a_ext + 14'sd6434;

        xs    = {{(IW-16){x0[11]}}, x0, 4'b0000};
        ys    = {{(IW-16){y0[11]}}, y0, 4'b0000};
        x_pre = xs;
        y_pre = ys;
        z_pre = a_red;
        // Strict compare keeps exactly +/-pi/2 in the CORDIC core's convergence range.
        if (a_red > 14'sd1608) begin
            x_pre = -ys;
            y_pre = xs;
            z_pre = a_red - 14'sd1608;
        end else if (a_red < -14'sd1608) begin
            x_pre = ys;
            y_pre = -xs;
            z_pre = a_red + 14'sd1608;
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            a0 <= '0;
            x0 <= '0;
            y0 <= '0;
            for (int unsigned i = 0; i <= ITER; i++) begin
                xp[i] <= '0;
                yp[i] <= '0;
                zp[i] <= '0;
            end
            xo <= '0;
            yo <= '0;
        end else begin
            a0 <= a;
            x0 <= x;
            y0 <= y;

            xp[0] <= x_pre;
            yp[0] <= y_pre;
            zp[0] <= {z_pre, 4'b0000};

            for (int unsigned i = 0; i < ITER; i++) begin
                if (!zp[i][ZW-1]) begin
                    xp[i+1] <= xp[i] - (yp[i] >>> i);
                    yp[i+1] <= yp[i] + (xp[i] >>> i);
                    zp[i+1] <= zp[i] - atan_rom(i);
                end else begin
                    xp[i+1] <= xp[i] + (yp[i] >>> i);
                    yp[i+1] <= yp[i] - (xp[i] >>> i);
                    zp[i+1] <= zp[i] + atan_rom(i);
                end
            end

            xo <= gain_round_sat(xp[ITER]);
            yo <= gain_round_sat(yp[ITER]);
        end
    end

endmodule

// File: tb/tb_cordic_rotator.sv
// Directed bench for cordic_rotator: every driven cycle queues its expected output,
// which is compared 15 clocks later against a real-valued rotation model.
module tb_cordic_rotator;

    logic        clk = 1'b0;
    logic        areset = 1'b1;
    logic [12:0] a = '0;
    logic [11:0] x = '0;
    logic [11:0] y = '0;
    logic [9:0]  xo;
    logic [9:0]  yo;

    cordic_rotator #(.ITER(12), .IW(18)) dut (
        .clk(clk),
        .areset(areset),
        .a(a),
        .x(x),
        .y(y),
        .xo(xo),
        .yo(yo)
    );

    always #5 clk = ~clk;

    typedef struct {
        int due;
        int ex;
        int ey;
        bit exact;
        int id;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   nid = 0;
    int   errors = 0;
    int   checks = 0;

    always @(posedge clk) cyc++;

    function automatic int model(input int ai, input int xi, input int yi, input bit is_x);
        real ang;
        real xr;
        real yr;
        real v;
        int  r;
        ang = ai / 1024.0;
        xr  = xi / 1024.0;
        yr  = yi / 1024.0;
        if (is_x) v = xr * $cos(ang) - yr * $sin(ang);
        else      v = xr * $sin(ang) + yr * $cos(ang);
        v = v * 256.0;
        r = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
        if (r > 511)  r = 511;
        if (r < -512) r = -512;
        return r;
    endfunction

    task automatic check(input string tag, input int got, input int exp, input int tol);
        int d;
        d = got - exp;
        checks++;
        assert ((d >= -tol && d <= tol) === 1'b1)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d (tol %0d)", tag, got, exp, tol);
        end
    endtask

    task automatic drive(input int ai, input int xi, input int yi, input bit rst);
        exp_t e;
        @(negedge clk);
        #1;
        areset = rst;
        a = 13'(ai);
        x = 12'(xi);
        y = 12'(yi);
        if (rst) begin
            foreach (q[k]) begin
                q[k].exact = 1'b1;
                q[k].ex = 0;
                q[k].ey = 0;
            end
        end
        e.due = cyc + 15;
        e.id  = nid++;
        if (rst || (xi == 0 && yi == 0)) begin
            e.exact = 1'b1;
            e.ex = 0;
            e.ey = 0;
        end else begin
            e.exact = 1'b0;
            e.ex = model(ai, xi, yi, 1'b1);
            e.ey = model(ai, xi, yi, 1'b0);
        end
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() != 0 && q[0].due < cyc) begin
            e = q.pop_front();
            checks++;
            errors++;
            $error("FAIL s%0d_missed: observed cycle %0d expected cycle %0d", e.id, cyc, e.due);
        end else if (q.size() != 0 && q[0].due == cyc) begin
            e = q.pop_front();
            check($sformatf("s%0d_xo", e.id), int'($signed(xo)), e.ex, e.exact ? 0 : 2);
            check($sformatf("s%0d_yo", e.id), int'($signed(yo)), e.ey, e.exact ? 0 : 2);
        end
    end

    initial begin
        // Reset held with non-zero inputs: outputs must stay zero.
        for (int i = 0; i < 3; i++) begin
            drive(804, 512, 300, 1'b1);
            #1;
            check("rst_xo", int'($signed(xo)), 0, 0);
            check("rst_yo", int'($signed(yo)), 0, 0);
        end

        drive(0, 512, 0, 1'b0);
        drive(0, 0, 0, 1'b0);
        drive(804, 512, 0, 1'b0);
        drive(0, 0, 0, 1'b0);
        drive(1608, 512, 0, 1'b0);
        drive(-1608, 512, 0, 1'b0);
        drive(1609, 512, 0, 1'b0);
        drive(3216, -352, 0, 1'b0);
        drive(-3217, 300, 200, 1'b0);
        drive(804, 2047, 2047, 1'b0);
        drive(-804, -400, 700, 1'b0);
        drive(2500, 0, 0, 1'b0);
        drive(-2000, 1000, -600, 1'b0);
        drive(0, 0, 0, 1'b0);

        // Streaming sweep with a mid-stream reset pulse.
        for (int k = 1; k <= 18; k++)
            drive(804, 16 * k, 0, (k == 10 || k == 11));

        drive(0, 0, 0, 1'b0);
        for (int i = 0; i < 40 && q.size() != 0; i++)
            @(negedge clk);
        if (q.size() != 0) begin
            checks++;
            errors++;
            $error("FAIL drain_timeout: observed %0d pending expected 0", q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
